iter_shifter: RTL

- Multi-cycle serial shift unit in the execute stage. It sits beside the ALU and handles SLL, SRL, SRA and ROR with a register shift amount.
- Shifts one bit per cycle under a start/busy/done handshake, in the same style as the multiply/divide unit.
- Its result feeds the EX/MEM result mux, and its busy output feeds hazard stall logic.

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_step.sv | 25 ++
 rtl/iter_shifter.sv | 72 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the iterative shift unit: op-codes and FSM state encodings.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step; pure combinational, used once per cycle by iter_shifter.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] nxt
);

    logic signed [WIDTH-1:0] acc_s;

    always_comb begin
        acc_s = acc;
        nxt   = acc;
        case (op)
            OP_SLL: nxt = {acc[WIDTH-2:0], 1'b0};
            OP_SRL: nxt = {1'b0, acc[WIDTH-1:1]};
            OP_SRA: nxt = $unsigned(acc_s >>> 1);
            OP_ROR: nxt = {acc[0], acc[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Serial shifter beside the ALU: one bit per cycle under a start/busy/done handshake.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state;
    logic [1:0]       opr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] stepped;
    logic [SHW-1:0]   cnt;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op  (opr),
        .acc (acc),
        .nxt (stepped)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            opr    <= OP_SLL;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new request directly so back-to-back ops lose no cycle
                    if (start) begin
                        acc <= a;
                        cnt <= b;
                        opr <= op;
                        if (b == '0) begin
                            result <= a;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_SHIFT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    acc <= stepped;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= stepped;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule
